// File: rtl/yc_sep_pkg.sv
// Shared types for the Y/C separator: filter mode and control-state encodings.
package yc_sep_pkg;

    typedef enum logic {
        MODE_BOXCAR = 1'b0,
        MODE_COMB   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/yc_separator_stream_if.sv
// Sample stream into the separator and luma/chroma results out of it.
interface yc_separator_stream_if #(
    parameter int DATA_WIDTH = 12
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] luma_out;
    logic signed [DATA_WIDTH-1:0] chroma_out;
    logic                         sat_flag;

    modport master (
        output in_valid, data_in,
        input  in_ready, out_valid, luma_out, chroma_out, sat_flag
    );

    modport slave (
        input  in_valid, data_in,
        output in_ready, out_valid, luma_out, chroma_out, sat_flag
    );
endinterface

// File: rtl/yc_delay_line.sv
// History of accepted samples; taps[0] is the sample accepted one step before the current one.
module yc_delay_line #(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_WINDOW = 32,
    parameter int COMB_DELAY = 2
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic signed [DATA_WIDTH-1:0]      din,
    input  logic [$clog2(MAX_WINDOW)-1:0]     n_idx,
    input  logic [$clog2(MAX_WINDOW)-1:0]     half_idx,
    output logic signed [DATA_WIDTH-1:0]      tap_oldest,
    output logic signed [DATA_WIDTH-1:0]      tap_center,
    output logic signed [DATA_WIDTH-1:0]      tap_comb
);
    logic signed [DATA_WIDTH-1:0] taps [MAX_WINDOW];

    // No reset: stale contents are masked out by the fill logic upstream.
    always_ff @(posedge clk) begin
        if (en) begin
            taps[0] <= din;
            for (int i = 1; i < MAX_WINDOW; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign tap_oldest = taps[n_idx];
    assign tap_center = taps[half_idx];
    assign tap_comb   = taps[COMB_DELAY-1];
endmodule

// File: rtl/yc_separator_stream.sv
// Streaming luma/chroma separator: boxcar mean or two-tap comb, saturated chroma, config-change flush.
module yc_separator_stream
    import yc_sep_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_WINDOW = 32,
    parameter int COMB_DELAY = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [$clog2(MAX_WINDOW):0]   win_log2,
    yc_separator_stream_if.slave          bus
);
    localparam int WL = $clog2(MAX_WINDOW);
    localparam int AW = DATA_WIDTH + WL + 1;
    localparam logic [WL:0]   WL_TOP   = (WL+1)'(WL);
    localparam logic [WL-1:0] WL_CLAMP = WL'(WL);
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = {2'b11, {(DATA_WIDTH-1){1'b0}}};

    state_e                       state;
    mode_e                        cfg_mode, live_mode;
    logic [WL-1:0]                cfg_wl, live_wl;
    logic signed [AW-1:0]         acc, acc_next, old_term;
    logic [WL:0]                  fill, fill_inc, n_val, thresh;
    logic [WL-1:0]                n_idx, half_idx;
    logic signed [DATA_WIDTH-1:0] x, tap_oldest, tap_center, tap_comb;
    logic signed [DATA_WIDTH-1:0] luma_box, luma_comb, luma_new, ref_s, chroma_new;
    logic signed [DATA_WIDTH:0]   comb_sum, diff;
    logic signed [DATA_WIDTH-1:0] luma_q, chroma_q;
    logic                         valid_q, sat_q, sat_new;
    logic                         accept, reach, cfg_changed;

    assign live_mode   = mode_e'(mode);
    assign live_wl     = (win_log2 > WL_TOP) ? WL_CLAMP : win_log2[WL-1:0];
    assign cfg_changed = (live_mode != cfg_mode) || (live_wl != cfg_wl);

    assign bus.in_ready   = (state != ST_FLUSH);
    assign accept         = bus.in_valid && bus.in_ready;
    assign x              = bus.data_in;
    assign bus.out_valid  = valid_q;
    assign bus.luma_out   = luma_q;
    assign bus.chroma_out = chroma_q;
    assign bus.sat_flag   = sat_q;

    assign n_val    = (WL+1)'(1) << cfg_wl;
    assign n_idx    = WL'(n_val - (WL+1)'(1));
    assign half_idx = (cfg_wl == '0) ? '0 : WL'((n_val >> 1) - (WL+1)'(1));
    assign thresh   = (cfg_mode == MODE_COMB) ? (WL+1)'(COMB_DELAY + 1) : n_val;

    yc_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WINDOW (MAX_WINDOW),
        .COMB_DELAY (COMB_DELAY)
    ) u_delay (
        .clk        (clk),
        .en         (accept),
        .din        (x),
        .n_idx      (n_idx),
        .half_idx   (half_idx),
        .tap_oldest (tap_oldest),
        .tap_center (tap_center),
        .tap_comb   (tap_comb)
    );

    // Results for the sample on the bus this cycle, including x[n] itself.
    always_comb begin
        old_term   = (state == ST_FILL) ? '0 : AW'(tap_oldest);
        acc_next   = acc + AW'(x) - old_term;
        luma_box   = DATA_WIDTH'(acc_next >>> cfg_wl);
        comb_sum   = (DATA_WIDTH+1)'(x) + (DATA_WIDTH+1)'(tap_comb);
        luma_comb  = DATA_WIDTH'(comb_sum >>> 1);
        luma_new   = (cfg_mode == MODE_COMB) ? luma_comb : luma_box;
        ref_s      = (cfg_mode == MODE_COMB || cfg_wl == '0) ? x : tap_center;
        diff       = (DATA_WIDTH+1)'(ref_s) - (DATA_WIDTH+1)'(luma_new);
        sat_new    = 1'b0;
        chroma_new = DATA_WIDTH'(diff);
        if (diff > SAT_MAX) begin
            chroma_new = DATA_WIDTH'(SAT_MAX);
            sat_new    = 1'b1;
        end else if (diff < SAT_MIN) begin
            chroma_new = DATA_WIDTH'(SAT_MIN);
            sat_new    = 1'b1;
        end
        fill_inc = (fill < thresh) ? fill + (WL+1)'(1) : fill;
        reach    = (fill_inc >= thresh);
    end

    // A config change always costs one FLUSH cycle; the sample on that edge still uses the old config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            acc      <= '0;
            fill     <= '0;
            cfg_mode <= live_mode;
            cfg_wl   <= live_wl;
            valid_q  <= 1'b0;
            luma_q   <= '0;
            chroma_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_FILL, ST_RUN: begin
                    if (accept) begin
                        fill <= fill_inc;
                        if (cfg_mode == MODE_BOXCAR) begin
                            acc <= acc_next;
                        end
                        if (reach) begin
                            valid_q  <= 1'b1;
                            luma_q   <= luma_new;
                            chroma_q <= chroma_new;
                            sat_q    <= sat_new;
                        end
                    end
                    if (cfg_changed) begin
                        state <= ST_FLUSH;
                    end else if (accept && reach) begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    acc      <= '0;
                    fill     <= '0;
                    cfg_mode <= live_mode;
                    cfg_wl   <= live_wl;
                    state    <= ST_FILL;
                end
                default: state <= ST_FILL;
            endcase
        end
    end
endmodule

// File: doc/yc_separator_stream.md
YC_SEPARATOR_STREAM -- requirements
Module: yc_separator_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 12, SHALL set the signed sample width of input and outputs.
REQ-002 Parameter MAX_WINDOW, default 32, SHALL set the maximum boxcar length and SHALL be a power of two, 2..256.
REQ-003 Parameter COMB_DELAY, default 2, SHALL set the comb-mode tap distance in samples, 1..MAX_WINDOW-1.
REQ-004 Clocking and reset SHALL be fixed as one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = boxcar, 1 = comb
- win_log2  in  $clog2(MAX_WINDOW)+1  boxcar length exponent, N = 2^win_log2
- in_valid  in  1  data_in qualifier
- in_ready  out  1  block can accept a sample
- data_in  in  DATA_WIDTH  signed composite sample
- out_valid  out  1  one-cycle pulse, outputs updated
- luma_out  out  DATA_WIDTH  signed luma
- chroma_out  out  DATA_WIDTH  signed chroma, saturated
- sat_flag  out  1  chroma_out was clipped on this out_valid

Function
REQ-006 A sample SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the delay line, accumulator and fill count SHALL advance only on acceptance.
REQ-007 win_log2 above $clog2(MAX_WINDOW) SHALL be clamped to $clog2(MAX_WINDOW).
REQ-008 State machine SHALL have states FILL, RUN and FLUSH; in_ready SHALL be 1 in FILL and RUN, and 0 in FLUSH.
REQ-009 Boxcar mode: acc SHALL hold the sum of the last N accepted samples; luma = acc >>> win_log2 (arithmetic); center = x[n - N/2] (x[n] when N = 1); chroma = center - luma.
REQ-010 Comb mode: luma = (x[n] + x[n-COMB_DELAY]) >>> 1; chroma = x[n] - luma.
REQ-011 The accumulator SHALL be DATA_WIDTH+$clog2(MAX_WINDOW)+1 bits signed and SHALL never overflow.
REQ-012 The chroma difference SHALL be computed at DATA_WIDTH+1 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat_flag SHALL be 1 exactly when clipping occurs.
REQ-013 Outputs SHALL be registered on the accepting edge and SHALL include x[n]; latency is 1 cycle.
REQ-014 Each output (luma_out, chroma_out, sat_flag) SHALL hold its value between accepted samples.
REQ-015 The fill count SHALL saturate; FILL SHALL move to RUN when the accepted count reaches the threshold: N in boxcar mode, COMB_DELAY+1 in comb mode.
REQ-016 out_valid SHALL pulse on each accepting edge whose sample completes or follows the threshold, and SHALL be 0 otherwise.
REQ-017 While filling, the subtracted oldest-sample term SHALL be masked to 0, so stale delay-line contents never reach acc.
REQ-018 The live mode/win_log2 SHALL be compared every cycle with the latched config; on a difference in FILL or RUN, the next state SHALL be FLUSH.
REQ-019 A sample accepted on the same edge as a config change SHALL be processed with the old config.
REQ-020 FLUSH SHALL last exactly one cycle: clear acc and fill count, latch the new config, go to FILL, and not assert out_valid.

Reset
REQ-021 While rst_n = 0: state FILL, acc 0, fill count 0, config latched from ports, luma_out/chroma_out 0, out_valid 0, sat_flag 0.
REQ-022 The delay line SHALL have no reset; correctness SHALL rely on REQ-017.
REQ-023 Reset asserted mid-stream SHALL discard all history, with no out_valid until the threshold is refilled.

Structure
REQ-024 Package yc_sep_pkg SHALL hold the mode enum (MODE_BOXCAR, MODE_COMB) and the state enum (ST_FILL, ST_RUN, ST_FLUSH).
REQ-025 Sub-module yc_delay_line SHALL implement the enable-gated MAX_WINDOW-deep shift register, with variable taps at N-1, N/2-1 and COMB_DELAY-1.

Verification (DATA_WIDTH=12, MAX_WINDOW=32, COMB_DELAY=2)
REQ-026 Reset then release -> all outputs 0, in_ready 1, out_valid 0.
REQ-027 Boxcar, win_log2=2, constant 100 every cycle -> first out_valid on the 4th accepted sample, with luma 100 and chroma 0, then one out_valid per cycle.
REQ-028 Comb mode, inputs -2048, -2048, 2047 -> third output luma -1, chroma 2047, sat_flag 1.
REQ-029 Boxcar, win_log2=2, input +1000/-1000 alternating with in_valid toggling -> luma 0, chroma ±1000 matching x[n-2], out_valid only on accepting edges, outputs held between them.
REQ-030 In RUN, change win_log2 2->3 -> in_ready 0 for exactly one cycle, then no out_valid until 8 new samples are accepted, then correct 8-sample mean.
REQ-031 Reset pulsed after 10 samples in RUN -> outputs 0 immediately, and refill needs the full threshold again.
